// File: rtl/fb_arbiter.sv
// fb_arbiter: owns the single port of the frame buffer RAM and shares it
// between the VGA scan-out reader, a full-screen fill engine and the game
// renderer. The priority order is fixed: VGA first, then the fill engine,
// then the renderer.
module fb_arbiter #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  // VGA scan-out reader
  input  logic               vga_rd_en,
  input  logic [9:0]         vga_x,
  input  logic [9:0]         vga_y,
  output logic [COLOR_W-1:0] vga_pixel,
  output logic               vga_pixel_valid,
  // Renderer pixel writer
  input  logic               wr_req,
  input  logic [9:0]         wr_x,
  input  logic [9:0]         wr_y,
  input  logic [COLOR_W-1:0] wr_color,
  output logic               wr_ack,
  output logic               wr_oob,
  // Fill engine control
  input  logic               clr_start,
  input  logic [COLOR_W-1:0] clr_color,
  output logic               clr_busy,
  output logic               clr_done,
  // Frame buffer port
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_din,
  output logic               mem_we,
  input  logic [COLOR_W-1:0] mem_dout
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [9:0]        H_LIM  = 10'(H_RES);
  localparam logic [9:0]        V_LIM  = 10'(V_RES);
  localparam logic [ADDR_W-1:0] H_MUL  = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(H_RES * V_RES - 1);

  // Linear address of (x, y); widened to ADDR_W before the multiply so the
  // largest legal address fits without truncation.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [9:0] x,
                                                 input logic [9:0] y);
    return ADDR_W'(y) * H_MUL + ADDR_W'(x);
  endfunction

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    fill_cnt;
  logic [COLOR_W-1:0]   fill_color;
  logic                 rd_pending;
  logic                 vga_in_range, wr_in_range;
  logic [ADDR_W-1:0]    vga_addr, wr_addr;
  logic                 grant_fill, grant_wr, fill_last;

  assign clr_busy  = (state_q == CLEAR);
  // The RAM registers its read data, so the pixel is simply forwarded.
  assign vga_pixel = mem_dout;

  // Address decode, grant selection and next-state logic for the fill FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d      = state_q;
    vga_in_range = (vga_x < H_LIM) && (vga_y < V_LIM);
    wr_in_range  = (wr_x < H_LIM) && (wr_y < V_LIM);
    vga_addr     = vga_in_range ? lin_addr(vga_x, vga_y) : '0;
    wr_addr      = lin_addr(wr_x, wr_y);
    fill_last    = (fill_cnt == LAST_A);
    grant_fill   = !vga_rd_en && (state_q == CLEAR);
    // A start pulse in IDLE pre-empts the renderer for that cycle, and the
    // cycle carrying wr_ack must not grant the same request a second time.
    grant_wr     = !vga_rd_en && (state_q == IDLE) && !clr_start &&
                   wr_req && !wr_ack;

    unique case (state_q)
      IDLE:    if (clr_start) state_d = CLEAR;
      CLEAR:   if (grant_fill && fill_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fill FSM state, fill counter and latched fill colour.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every register samples the values from before this edge.
    if (rst) begin
      state_q    <= IDLE;
      fill_cnt   <= '0;
      fill_color <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && clr_start) begin
        fill_cnt   <= '0;
        fill_color <= clr_color;
      end else if (grant_fill) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  // Registered RAM port, read-valid pipeline and handshake pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr        <= '0;
      mem_din         <= '0;
      mem_we          <= 1'b0;
      rd_pending      <= 1'b0;
      vga_pixel_valid <= 1'b0;
      wr_ack          <= 1'b0;
      wr_oob          <= 1'b0;
      clr_done        <= 1'b0;
    end else begin
      // Address goes out on this edge, RAM data lands on the next one.
      rd_pending      <= vga_rd_en;
      vga_pixel_valid <= rd_pending;
      wr_ack          <= grant_wr;
      wr_oob          <= grant_wr && !wr_in_range;
      clr_done        <= grant_fill && fill_last;

      if (vga_rd_en) begin
        mem_addr <= vga_addr;
        mem_we   <= 1'b0;
      end else if (grant_fill) begin
        mem_addr <= fill_cnt;
        mem_din  <= fill_color;
        mem_we   <= 1'b1;
      end else if (grant_wr && wr_in_range) begin
        mem_addr <= wr_addr;
        mem_din  <= wr_color;
        mem_we   <= 1'b1;
      end else begin
        // Idle or an out-of-range renderer write: address holds, no write.
        mem_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed stimulus with a scoreboard. The frame buffer is a
// reduced 64x48 screen so that full-screen fills stay short; all expected
// addresses below are computed for that geometry.
module tb_fb_arbiter;

  localparam int H = 64;
  localparam int V = 48;
  localparam int N = H * V;          // 3072 pixels, last address 3071

  typedef struct packed {
    logic [18:0] addr;
    logic [8:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_rd_en;
  logic [9:0]  vga_x, vga_y;
  logic [8:0]  vga_pixel;
  logic        vga_pixel_valid;
  logic        wr_req;
  logic [9:0]  wr_x, wr_y;
  logic [8:0]  wr_color;
  logic        wr_ack, wr_oob;
  logic        clr_start;
  logic [8:0]  clr_color;
  logic        clr_busy, clr_done;
  logic [18:0] mem_addr;
  logic [8:0]  mem_din;
  logic        mem_we;
  logic [8:0]  mem_dout;

  // Bench RAM model and scoreboard state
  logic [8:0]  ram [0:4095];
  logic        init_mem = 1'b1;
  logic        mon_en   = 1'b0;
  logic [8:0]  rd_q  [$];
  wr_t         wr_q  [$];
  logic        ack_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  fb_arbiter #(.H_RES(H), .V_RES(V), .ADDR_W(19), .COLOR_W(9)) dut (
    .clk(clk), .rst(rst),
    .vga_rd_en(vga_rd_en), .vga_x(vga_x), .vga_y(vga_y),
    .vga_pixel(vga_pixel), .vga_pixel_valid(vga_pixel_valid),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .wr_ack(wr_ack), .wr_oob(wr_oob),
    .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout)
  );

  // Single-port RAM with registered read data (read-before-write).
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 4096; i++) ram[i] <= '0;
      ram[133] <= 9'h1A5;
    end else if (mem_we) begin
      ram[mem_addr[11:0]] <= mem_din;
    end
    mem_dout <= ram[mem_addr[11:0]];
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents one.
  always @(negedge clk) begin
    if (mon_en) begin
      if (vga_pixel_valid) begin
        check("rd_expected", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) check("vga_pixel", vga_pixel, rd_q.pop_front());
      end
      if (mem_we) begin
        check("wr_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", mem_addr, w.addr);
          check("wr_data", mem_din, w.data);
        end
      end
      if (wr_ack) begin
        check("ack_expected", 32'(ack_q.size() != 0), 1);
        if (ack_q.size() != 0) check("wr_oob", wr_oob, ack_q.pop_front());
      end
      check("oob_without_ack", wr_oob & ~wr_ack, 0);
      if (clr_done) done_cnt++;
    end
  end

  task automatic push_fill(input logic [8:0] color);
    for (int i = 0; i < N; i++) wr_q.push_back('{addr: 19'(i), data: color});
  endtask

  task automatic check_reset_state();
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_valid", vga_pixel_valid, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_wr_oob", wr_oob, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_clr_done", clr_done, 0);
  endtask

  initial begin
    rst = 1'b1; vga_rd_en = 1'b0; vga_x = '0; vga_y = '0;
    wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
    clr_start = 1'b0; clr_color = '0;
    repeat (2) @(negedge clk);
    init_mem = 1'b0;
    rst = 1'b0;

    // ---- Reset in the middle of activity (fill running, renderer pending)
    vga_rd_en = 1'b1; vga_x = 10'd3; wr_req = 1'b1; wr_x = 10'd2;
    clr_start = 1'b1; clr_color = 9'h000;
    @(negedge clk);
    clr_start = 1'b0; vga_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mem_we_after_rst", mem_we, 0);
    check("busy_after_rst", clr_busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; wr_req = 1'b0;
    check_reset_state();
    mon_en = 1'b1;

    // ---- Read latency: (5,2) -> 2*64+5 = 133, preloaded with 9'h1A5
    vga_rd_en = 1'b1; vga_x = 10'd5; vga_y = 10'd2;
    rd_q.push_back(9'h1A5);
    @(negedge clk);
    vga_rd_en = 1'b0;
    check("rd_addr", mem_addr, 133);
    check("rd_valid_e0", vga_pixel_valid, 0);
    @(negedge clk);
    check("rd_valid_e1", vga_pixel_valid, 1);
    @(negedge clk);
    check("rd_valid_e2", vga_pixel_valid, 0);

    // ---- Renderer contention: write (63,47) -> 3071 while VGA reads 4 cycles
    wr_req = 1'b1; wr_x = 10'd63; wr_y = 10'd47; wr_color = 9'h1FF;
    ack_q.push_back(1'b0);
    wr_q.push_back('{addr: 19'd3071, data: 9'h1FF});
    vga_rd_en = 1'b1; vga_x = 10'd0; vga_y = 10'd0;
    for (int i = 0; i < 4; i++) begin
      rd_q.push_back(9'h000);
      @(negedge clk);
      check("no_ack_during_vga", wr_ack, 0);
    end
    vga_rd_en = 1'b0;
    @(negedge clk);
    check("ack_after_vga", wr_ack, 1);
    check("wr_mem_addr", mem_addr, 3071);
    check("wr_mem_we", mem_we, 1);
    // Request deliberately still held in the ack cycle: must not be regranted.
    @(negedge clk);
    check("no_double_ack", wr_ack, 0);
    check("no_double_we", mem_we, 0);
    wr_req = 1'b0;
    vga_rd_en = 1'b1; vga_x = 10'd63; vga_y = 10'd47;
    rd_q.push_back(9'h1FF);
    @(negedge clk);
    vga_rd_en = 1'b0;
    repeat (3) @(negedge clk);

    // ---- Out-of-range renderer write: x=64 is dropped with wr_oob
    wr_req = 1'b1; wr_x = 10'd64; wr_y = 10'd0; wr_color = 9'h0C3;
    ack_q.push_back(1'b1);
    @(negedge clk);
    check("oob_ack", wr_ack, 1);
    check("oob_flag", wr_oob, 1);
    check("oob_no_we", mem_we, 0);
    wr_req = 1'b0;
    @(negedge clk);
    check("oob_ack_clear", wr_ack, 0);

    // ---- Full clear with 9'h007, renderer request raised with clr_start,
    //      and a second clr_start (9'h0F0) mid-fill that must be ignored.
    push_fill(9'h007);
    wr_q.push_back('{addr: 19'd65, data: 9'h055});   // (1,1) after the fill
    ack_q.push_back(1'b0);
    clr_start = 1'b1; clr_color = 9'h007;
    wr_req = 1'b1; wr_x = 10'd1; wr_y = 10'd1; wr_color = 9'h055;
    @(negedge clk);
    clr_start = 1'b0;
    check("clear_busy", clr_busy, 1);
    check("clear_start_no_ack", wr_ack, 0);
    begin
      logic acked = 1'b0;
      for (int i = 0; i < N + 100 && !acked; i++) begin
        if (i == 100) begin clr_start = 1'b1; clr_color = 9'h0F0; end
        if (i == 101) clr_start = 1'b0;
        @(negedge clk);
        if (wr_ack) begin
          acked = 1'b1;
          check("ack_after_busy", clr_busy, 0);
          check("done_once", done_cnt, 1);
        end
      end
      check("clear_ack_seen", acked, 1);
    end
    wr_req = 1'b0;
    @(negedge clk);
    check("clear_writes_drained", wr_q.size(), 0);
    // Back-to-back reads: (1,1) renderer pixel, then (5,2) filled pixel
    vga_rd_en = 1'b1; vga_x = 10'd1; vga_y = 10'd1;
    rd_q.push_back(9'h055);
    @(negedge clk);
    vga_x = 10'd5; vga_y = 10'd2;
    rd_q.push_back(9'h007);
    @(negedge clk);
    vga_rd_en = 1'b0;
    @(negedge clk);
    check("b2b_second_valid", vga_pixel_valid, 1);
    repeat (2) @(negedge clk);

    // ---- Clear with 9'h0AA while VGA reads every other cycle. Reads use an
    //      out-of-range coordinate, clamped to address 0 (already refilled).
    push_fill(9'h0AA);
    clr_start = 1'b1; clr_color = 9'h0AA;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (6) @(negedge clk);
    vga_x = 10'd700; vga_y = 10'd3;
    for (int i = 0; i < 3 * N && done_cnt < 2; i++) begin
      vga_rd_en = ~vga_rd_en;
      if (vga_rd_en) rd_q.push_back(9'h0AA);
      @(negedge clk);
      if (vga_rd_en) check("busy_during_reads", clr_busy, 32'(done_cnt < 2));
    end
    vga_rd_en = 1'b0;
    repeat (4) @(negedge clk);
    check("interleaved_done", done_cnt, 2);
    check("interleaved_writes_drained", wr_q.size(), 0);
    check("interleaved_reads_drained", rd_q.size(), 0);

    // ---- Reset at fill counter 1000: writes 0..1000 land, then nothing.
    for (int i = 0; i <= 1000; i++) wr_q.push_back('{addr: 19'(i), data: 9'h0BB});
    clr_start = 1'b1; clr_color = 9'h0BB;
    @(negedge clk);
    clr_start = 1'b0;
    begin
      logic hit = 1'b0;
      for (int i = 0; i < 2000 && !hit; i++) begin
        if (mem_we && mem_addr == 19'd1000) hit = 1'b1;
        else @(negedge clk);
      end
      check("reached_1000", hit, 1);
    end
    rst = 1'b1; vga_rd_en = 1'b1; wr_req = 1'b1;
    @(negedge clk);
    check("midclear_we", mem_we, 0);
    check("midclear_busy", clr_busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; vga_rd_en = 1'b0; wr_req = 1'b0;
    check_reset_state();
    repeat (10) @(negedge clk);
    check("no_done_after_rst", done_cnt, 2);
    check("idle_after_rst", clr_busy, 0);
    check("midclear_writes_drained", wr_q.size(), 0);
    check("acks_drained", ack_q.size(), 0);
    check("reads_drained", rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Owns the single port of the 640x480x9-bit frame buffer RAM (one address, one write enable, registered read data).
- Shares that port between three requesters:
  - VGA scan-out reader: highest priority, never stalled.
  - Full-screen clear/fill engine.
  - Game renderer pixel writer, using a req/ack handshake.
- Converts (x,y) coordinates to linear addresses and returns read pixels with fixed latency.

Parameters:
- H_RES, 640, horizontal pixels per line.
- V_RES, 480, lines per frame.
- ADDR_W, 19, frame buffer address width.
- COLOR_W, 9, pixel width (3 bits each for R, G, B).

Ports:
- clk  in  1  system clock, shared with the frame buffer.
- rst  in  1  synchronous active-high reset.
- vga_rd_en  in  1  VGA requests the pixel at vga_x, vga_y this cycle.
- vga_x  in  10  VGA column.
- vga_y  in  10  VGA row.
- vga_pixel  out  COLOR_W  pixel returned to VGA.
- vga_pixel_valid  out  1  vga_pixel is valid this cycle.
- wr_req  in  1  renderer write request; held until acked.
- wr_x  in  10  renderer column.
- wr_y  in  10  renderer row.
- wr_color  in  COLOR_W  renderer pixel colour.
- wr_ack  out  1  one-cycle pulse when the renderer request is consumed.
- wr_oob  out  1  one-cycle pulse, coincident with wr_ack, when the request was out of range and dropped.
- clr_start  in  1  pulse that starts a full-screen fill.
- clr_color  in  COLOR_W  fill colour, latched on an accepted clr_start.
- clr_busy  out  1  fill in progress.
- clr_done  out  1  one-cycle pulse after the last fill write is issued.
- mem_addr  out  ADDR_W  frame buffer address (registered).
- mem_din  out  COLOR_W  frame buffer write data (registered).
- mem_we  out  1  frame buffer write enable (registered).
- mem_dout  in  COLOR_W  frame buffer read data (RAM registers it one cycle after the address).

Behaviour:
- Reset values: mem_addr=0, mem_din=0, mem_we=0, vga_pixel_valid=0, wr_ack=0, wr_oob=0, clr_busy=0, clr_done=0, FSM=IDLE, fill counter=0. vga_pixel passes mem_dout through unmodified; its value is meaningless while vga_pixel_valid=0.
- Address computation: addr = y*H_RES + x, computed at ADDR_W bits with no truncation inside the legal range (max 307199).
- Per-cycle arbitration, fixed priority, exactly one grant per cycle:
  1. vga_rd_en=1: mem_addr<=vga address, mem_we<=0.
  2. Else clr_busy=1: mem_addr<=fill counter, mem_din<=latched colour, mem_we<=1.
  3. Else wr_req=1: mem_addr<=renderer address, mem_din<=wr_color, mem_we<=1 (in range only); wr_ack<=1.
  4. Else: mem_we<=0, mem_addr holds.
- Read latency is 2 cycles:
  - vga_rd_en sampled at edge E0 → mem_addr registered at E0.
  - RAM registers data at E1 → vga_pixel=mem_dout and vga_pixel_valid=1 in the cycle after E1.
  - Back-to-back reads give one valid pixel per cycle.
- VGA is never stalled and never has data dropped. VGA requests outside the range are clamped to address 0; valid still asserts.
- Renderer handshake:
  - wr_ack rises in the cycle after the grant edge.
  - The renderer may change inputs or drop wr_req in the cycle wr_ack is high.
  - The arbiter must not grant the same request twice: no grant in the cycle wr_ack is high.
  - While clr_busy=1 the renderer is starved; no ack is issued.
  - x≥H_RES or y≥V_RES: ack is issued with wr_oob=1 and mem_we=0.
- Clear FSM (IDLE, CLEAR):
  - IDLE→CLEAR on clr_start: latch clr_color, counter=0, clr_busy=1.
  - In CLEAR: the counter increments only on cycles where the fill engine is granted.
  - After the write at address H_RES*V_RES-1 is granted: →IDLE, clr_busy=0, clr_done pulses 1 cycle.
  - clr_start while clr_busy=1 is ignored; the colour is not relatched.
- Simultaneous clr_start and wr_req in IDLE: the clear starts; the renderer grant is suppressed that cycle and the request stays pending.
- Reset mid-operation (rst=1 at any edge): everything returns to reset values, any fill is abandoned, and no clr_done is issued. Pending renderer requests are not acked; the renderer must reissue.

Test Plan:
- Reset: assert rst 3 cycles mid-activity → all outputs at reset values; mem_we=0 the cycle after rst.
- Read latency: vga_rd_en=1, x=5, y=2 at E0 → mem_addr=1285 after E0; vga_pixel_valid=1 exactly 2 cycles later with the preloaded value 9'h1A5.
- Renderer write, contention: wr_req with (639,479,9'h1FF) while vga_rd_en=1 for 4 cycles → no ack during VGA reads; ack the cycle after VGA drops; mem_addr=307199, mem_we=1 once; a later read returns 9'h1FF.
- Out of range: wr_req with x=640, y=0 → wr_ack=1 and wr_oob=1 together, no mem_we pulse.
- Full clear: clr_start, clr_color=9'h007, no VGA traffic → exactly 307200 mem_we pulses at addresses 0..307199; clr_done exactly once; renderer acked only after clr_busy falls. With VGA reading 1 of every 2 cycles → completes after 614400 fill/read cycles, all reads valid.
- Reset mid-clear and restart while busy: rst at fill counter 1000 → clr_busy=0, no clr_done. Second clr_start with 9'h0F0 during a fill → colour stays 9'h007.
